// File: rtl/spi_ram_pkg.sv
// spi_ram_pkg: command encodings and FSM states shared by the SPI RAM slave.
package spi_ram_pkg;
    typedef enum logic [1:0] {
        CMD_WR_ADDR = 2'b00,
        CMD_WR_DATA = 2'b01,
        CMD_RD_ADDR = 2'b10,
        CMD_RD_DATA = 2'b11
    } cmd_e;
    typedef enum logic [2:0] {IDLE, CMD, WR_ADDR, WR_DATA, RD_ADDR, RD_DATA, DONE} state_e;
endpackage

// File: rtl/spi_ram_burst_slave_if.sv
// spi_ram_burst_slave_if: SPI pin bundle between external master and the RAM slave.
interface spi_ram_burst_slave_if;
    logic ss_n;
    logic mosi;
    logic miso;
    modport master (output ss_n, output mosi, input miso);
    modport slave (input ss_n, input mosi, output miso);
endinterface

// File: rtl/spi_ram_sp_mem.sv
// spi_ram_sp_mem: single-port RAM with registered read; out-of-range writes drop, reads give zero.
module spi_ram_sp_mem #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_SIZE = 8,
    parameter int MEM_DEPTH = 256
) (
    input  logic                  clk,
    input  logic                  we_i,
    input  logic [ADDR_SIZE-1:0]  addr_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    output logic [DATA_WIDTH-1:0] rdata_o
);
    localparam logic [ADDR_SIZE:0] DEPTH = (ADDR_SIZE+1)'(MEM_DEPTH);
    logic [DATA_WIDTH-1:0] mem_q [MEM_DEPTH];
    logic in_range;
    assign in_range = {1'b0, addr_i} < DEPTH;
    always_ff @(posedge clk) begin
        if (we_i && in_range) mem_q[addr_i] <= wdata_i;
        rdata_o <= in_range ? mem_q[addr_i] : '0;
    end
endmodule

// File: rtl/spi_ram_burst_slave.sv
// spi_ram_burst_slave: SPI slave decoding a 2-bit command per frame, with burst
// read/write into internal RAM through auto-incrementing, wrapping pointers.
module spi_ram_burst_slave
    import spi_ram_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_SIZE = 8,
    parameter int MEM_DEPTH = 256
) (
    input logic clk,
    input logic rst_n,
    spi_ram_burst_slave_if.slave spi
);
    localparam int SW = DATA_WIDTH > ADDR_SIZE ? DATA_WIDTH : ADDR_SIZE;
    localparam int SHW = SW - 1;
    localparam int CW = $clog2(SW);
    localparam logic [ADDR_SIZE:0] DEPTH = (ADDR_SIZE+1)'(MEM_DEPTH);
    state_e state_q;
    logic cmd_q;
    logic [CW-1:0] cnt_q;
    logic [SHW-1:0] sh_q;
    logic [DATA_WIDTH-1:0] out_q, rdata, wdata;
    logic [ADDR_SIZE-1:0] wr_addr_q, rd_addr_q, wr_addr_d, rd_addr_d, mem_addr;
    logic word_done, addr_done, we;
    function automatic logic [ADDR_SIZE-1:0] next_addr(input logic [ADDR_SIZE-1:0] a);
        return ({1'b0, a} + 1'b1 >= DEPTH) ? '0 : a + 1'b1;
    endfunction
    assign wr_addr_d = next_addr(wr_addr_q);
    assign rd_addr_d = next_addr(rd_addr_q);
    assign word_done = cnt_q == CW'(DATA_WIDTH-1);
    assign addr_done = cnt_q == CW'(ADDR_SIZE-1);
    assign we = state_q == WR_DATA && !spi.ss_n && word_done;
    assign wdata = {sh_q[DATA_WIDTH-2:0], spi.mosi};
    // Read port tracks rd_addr_q every cycle so the next word is already registered at its load edge.
    assign mem_addr = state_q == WR_DATA ? wr_addr_q : rd_addr_q;
    assign spi.miso = out_q[DATA_WIDTH-1];
    spi_ram_sp_mem #(
        .DATA_WIDTH(DATA_WIDTH),
        .ADDR_SIZE(ADDR_SIZE),
        .MEM_DEPTH(MEM_DEPTH)
    ) u_mem (
        .clk(clk),
        .we_i(we),
        .addr_i(mem_addr),
        .wdata_i(wdata),
        .rdata_o(rdata)
    );
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cmd_q <= 1'b0;
            cnt_q <= '0;
            sh_q <= '0;
            out_q <= '0;
            wr_addr_q <= '0;
            rd_addr_q <= '0;
        end else if (spi.ss_n) begin
            state_q <= IDLE;
            out_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    cmd_q <= spi.mosi;
                    state_q <= CMD;
                end
                CMD: begin
                    cnt_q <= '0;
                    state_q <= {cmd_q, spi.mosi} == CMD_WR_ADDR ? WR_ADDR :
                               {cmd_q, spi.mosi} == CMD_WR_DATA ? WR_DATA :
                               {cmd_q, spi.mosi} == CMD_RD_ADDR ? RD_ADDR : RD_DATA;
                end
                WR_ADDR, RD_ADDR: begin
                    sh_q <= SHW'({sh_q, spi.mosi});
                    cnt_q <= cnt_q + 1'b1;
                    if (addr_done) begin
                        if (state_q == WR_ADDR) wr_addr_q <= {sh_q[ADDR_SIZE-2:0], spi.mosi};
                        else rd_addr_q <= {sh_q[ADDR_SIZE-2:0], spi.mosi};
                        state_q <= DONE;
                    end
                end
                WR_DATA: begin
                    sh_q <= SHW'({sh_q, spi.mosi});
                    cnt_q <= word_done ? '0 : cnt_q + 1'b1;
                    if (word_done) wr_addr_q <= wr_addr_d;
                end
                RD_DATA: begin
                    out_q <= cnt_q == '0 ? rdata : out_q << 1;
                    cnt_q <= word_done ? '0 : cnt_q + 1'b1;
                    if (cnt_q == '0) rd_addr_q <= rd_addr_d;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_spi_ram_burst_slave.sv
// tb_spi_ram_burst_slave: drives a 256-deep and a 200-deep slave with identical
// frames and compares MISO against an array model of both memories.
module tb_spi_ram_burst_slave;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic ss_n = 1'b1;
    logic mosi = 1'b0;
    always #5 clk = ~clk;
    spi_ram_burst_slave_if if_a ();
    spi_ram_burst_slave_if if_b ();
    assign if_a.ss_n = ss_n;
    assign if_a.mosi = mosi;
    assign if_b.ss_n = ss_n;
    assign if_b.mosi = mosi;
    spi_ram_burst_slave #(.MEM_DEPTH(256)) dut_a (.clk(clk), .rst_n(rst_n), .spi(if_a.slave));
    spi_ram_burst_slave #(.MEM_DEPTH(200)) dut_b (.clk(clk), .rst_n(rst_n), .spi(if_b.slave));
    int depth [2] = '{256, 200};
    logic [7:0] mem_m [2][256];
    int wr_p [2];
    int rd_p [2];
    int n_cmp = 0;
    int n_bad = 0;
    logic [7:0] q [$];
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask
    function automatic int inc(input int a, input int d);
        return (a + 1 >= d) ? 0 : a + 1;
    endfunction
    task automatic bit_out(input logic b);
        @(negedge clk);
        ss_n = 1'b0;
        mosi = b;
    endtask
    task automatic send(input logic [31:0] v, input int n);
        for (int i = n - 1; i >= 0; i--) bit_out(v[i]);
    endtask
    task automatic end_frame();
        @(negedge clk);
        ss_n = 1'b1;
        mosi = 1'b0;
        @(posedge clk);
        #1;
        chk("idle_miso_a", {31'b0, if_a.miso}, 0);
        chk("idle_miso_b", {31'b0, if_b.miso}, 0);
    endtask
    task automatic wr_addr(input int a);
        send(0, 2);
        send(a, 8);
        end_frame();
        for (int d = 0; d < 2; d++) wr_p[d] = a;
    endtask
    task automatic rd_addr(input int a);
        send(2, 2);
        send(a, 8);
        end_frame();
        for (int d = 0; d < 2; d++) rd_p[d] = a;
    endtask
    task automatic wr_data(input logic [7:0] words [$], input int part);
        send(1, 2);
        foreach (words[w]) begin
            send({24'b0, words[w]}, 8);
            for (int d = 0; d < 2; d++) begin
                if (wr_p[d] < depth[d]) mem_m[d][wr_p[d]] = words[w];
                wr_p[d] = inc(wr_p[d], depth[d]);
            end
        end
        if (part > 0) send($urandom, part);
        end_frame();
    endtask
    task automatic rd_data(input int nw);
        logic [7:0] e [2];
        send(3, 2);
        send($urandom, 1);
        for (int w = 0; w < nw; w++) begin
            for (int d = 0; d < 2; d++) begin
                e[d] = rd_p[d] < depth[d] ? mem_m[d][rd_p[d]] : 8'h00;
                rd_p[d] = inc(rd_p[d], depth[d]);
            end
            for (int i = 7; i >= 0; i--) begin
                @(negedge clk);
                chk("rd_bit_a", {31'b0, if_a.miso}, {31'b0, e[0][i]});
                chk("rd_bit_b", {31'b0, if_b.miso}, {31'b0, e[1][i]});
                mosi = 1'($urandom);
            end
        end
        // The edge carrying the last sampled bit also prefetches the next word.
        for (int d = 0; d < 2; d++) rd_p[d] = inc(rd_p[d], depth[d]);
        end_frame();
    endtask
    initial begin
        for (int d = 0; d < 2; d++) begin
            wr_p[d] = 0;
            rd_p[d] = 0;
        end
        repeat (2) @(negedge clk);
        chk("rst_miso_a", {31'b0, if_a.miso}, 0);
        chk("rst_miso_b", {31'b0, if_b.miso}, 0);
        rst_n = 1'b1;
        q = {};
        for (int i = 0; i < 256; i++) q.push_back(8'($urandom));
        wr_addr(0);
        wr_data(q, 0);
        // Reset asserted mid-burst: completed word stays, pointers return to zero.
        wr_addr(5);
        send(1, 2);
        send(32'h77, 8);
        for (int d = 0; d < 2; d++) mem_m[d][5] = 8'h77;
        send(3'b101, 3);
        #3 rst_n = 1'b0;
        #1;
        chk("async_rst_miso_a", {31'b0, if_a.miso}, 0);
        chk("async_rst_miso_b", {31'b0, if_b.miso}, 0);
        ss_n = 1'b1;
        for (int d = 0; d < 2; d++) begin
            wr_p[d] = 0;
            rd_p[d] = 0;
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        rd_data(1);
        rd_addr(0);
        rd_data(1);
        rd_addr(5);
        rd_data(1);
        q = '{8'hA5, 8'h3C};
        wr_addr(8'h10);
        wr_data(q, 0);
        rd_addr(8'h10);
        rd_data(2);
        q = '{8'h11, 8'h22};
        wr_addr(8'hFF);
        wr_data(q, 0);
        q = '{8'h33};
        wr_data(q, 0);
        rd_addr(8'hFF);
        rd_data(3);
        q = {};
        wr_addr(8'h40);
        wr_data(q, 5);
        q = '{8'h99};
        wr_data(q, 0);
        rd_addr(8'h40);
        rd_data(2);
        q = '{8'h5A, 8'h6B};
        wr_addr(8'hC7);
        wr_data(q, 0);
        rd_addr(8'hC7);
        rd_data(2);
        q = '{8'hFF};
        wr_addr(8'hD0);
        wr_data(q, 0);
        rd_addr(8'hD0);
        rd_data(1);
        for (int it = 0; it < 40; it++) begin
            case ($urandom_range(0, 3))
                0: wr_addr(int'($urandom_range(0, 255)));
                1: begin
                    q = {};
                    for (int i = 0; i < int'($urandom_range(1, 3)); i++) q.push_back(8'($urandom));
                    wr_data(q, int'($urandom_range(0, 7)));
                end
                2: rd_addr(int'($urandom_range(0, 255)));
                default: rd_data(int'($urandom_range(1, 3)));
            endcase
        end
        rd_addr(0);
        rd_data(4);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
